// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared types and encodings for the multicycle MIPS controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // What the ALU is being used for in the current state
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_ADDR  = 3'd2,
    CLS_SUB   = 3'd3,
    CLS_RTYPE = 3'd4,
    CLS_IMM   = 3'd5
  } alu_cls_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

  localparam logic [1:0] c_srcb_regb   = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
// ============================================================================
// mc_alu_decoder : maps (ALU usage class, op, funct) to alu_ctrl and ext_op
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [2:0] i_cls,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_ext_op,
  output logic       o_funct_valid
);

  logic [2:0] w_rtype_ctrl;

  always_comb begin
    w_rtype_ctrl  = c_alu_and;
    o_funct_valid = 1'b1;
    case (i_funct)
      c_fn_add: w_rtype_ctrl = c_alu_add;
      c_fn_sub: w_rtype_ctrl = c_alu_sub;
      c_fn_and: w_rtype_ctrl = c_alu_and;
      c_fn_or:  w_rtype_ctrl = c_alu_or;
      c_fn_slt: w_rtype_ctrl = c_alu_slt;
      default:  o_funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    o_alu_ctrl = c_alu_and;
    o_ext_op   = 1'b0;
    case (i_cls)
      CLS_ADD:   o_alu_ctrl = c_alu_add;
      CLS_ADDR: begin
        o_alu_ctrl = c_alu_add;
        o_ext_op   = 1'b1;
      end
      CLS_SUB:   o_alu_ctrl = c_alu_sub;
      CLS_RTYPE: o_alu_ctrl = w_rtype_ctrl;
      CLS_IMM: begin
        // Logical immediates are zero-extended, arithmetic ones sign-extended
        o_ext_op = 1'b1;
        case (i_op)
          c_op_slti: o_alu_ctrl = c_alu_slt;
          c_op_andi: begin
            o_alu_ctrl = c_alu_and;
            o_ext_op   = 1'b0;
          end
          c_op_ori: begin
            o_alu_ctrl = c_alu_or;
            o_ext_op   = 1'b0;
          end
          default:   o_alu_ctrl = c_alu_add;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller : multicycle MIPS control FSM (fetch/decode/execute/mem/wb)
// Optional retired-instruction counter enabled by MC_CONTROLLER_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic        ext_op,
  output logic        illegal,
  output logic [3:0]  state_o,
  output logic [31:0] instr_cnt
);

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_set_illegal;
  alu_cls_t   w_cls;
  logic       w_pc_en, w_iord, w_mem_write, w_ir_write, w_reg_write;
  logic       w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [1:0] w_pc_src, w_alu_src_b;
  logic [2:0] w_alu_ctrl;
  logic       w_ext_op, w_funct_valid;

  mc_alu_decoder u_alu_dec (
    .i_cls         (w_cls),
    .i_op          (op),
    .i_funct       (funct),
    .o_alu_ctrl    (w_alu_ctrl),
    .o_ext_op      (w_ext_op),
    .o_funct_valid (w_funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    w_cls         = CLS_NONE;
    w_pc_en       = 1'b0;
    w_pc_src      = c_pcsrc_alu;
    w_iord        = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = c_srcb_regb;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b = c_srcb_four;
        w_cls       = CLS_ADD;
        w_ir_write  = mem_ready;
        w_pc_en     = mem_ready;
        w_next      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_b = c_srcb_imm_sh;
        w_cls       = CLS_ADDR;
        case (op)
          c_op_lw, c_op_sw:       w_next = S_MEMADR;
          c_op_rtype:             w_next = S_RTYPEEX;
          c_op_beq, c_op_bne:     w_next = S_BRANCH;
          c_op_addi, c_op_slti,
          c_op_andi, c_op_ori:    w_next = S_IMMEX;
          c_op_j:                 w_next = S_JUMP;
          default:                w_set_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = c_srcb_imm;
        w_cls       = CLS_ADDR;
        if (op == c_op_lw)      w_next = S_MEMRD;
        else if (op == c_op_sw) w_next = S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        w_alu_src_a = 1'b1;
        w_cls       = CLS_RTYPE;
        if (w_funct_valid) w_next = S_ALUWB;
        else               w_set_illegal = 1'b1;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_cls       = CLS_SUB;
        w_pc_src    = c_pcsrc_aluout;
        w_pc_en     = (op == c_op_bne) ? ~zero : zero;
      end
      S_IMMEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = c_srcb_imm;
        w_cls       = CLS_IMM;
        w_next      = S_IMMWB;
      end
      S_IMMWB:  w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_src = c_pcsrc_jump;
        w_pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every strobe and select combinationally so an aborted
  // instruction cannot write in the cycle reset is first seen.
  assign pc_en      = rst_n & w_pc_en;
  assign iord       = rst_n & w_iord;
  assign mem_write  = rst_n & w_mem_write;
  assign ir_write   = rst_n & w_ir_write;
  assign reg_write  = rst_n & w_reg_write;
  assign reg_dst    = rst_n & w_reg_dst;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign alu_src_a  = rst_n & w_alu_src_a;
  assign ext_op     = rst_n & w_ext_op;
  assign pc_src     = rst_n ? w_pc_src    : 2'b00;
  assign alu_src_b  = rst_n ? w_alu_src_b : 2'b00;
  assign alu_ctrl   = rst_n ? w_alu_ctrl  : 3'b000;
  assign illegal    = r_illegal;
  assign state_o    = r_state;

`ifdef MC_CONTROLLER_PERF_EN
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_cnt <= 32'd0;
    end else if (r_state != S_FETCH && w_next == S_FETCH) begin
      r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign instr_cnt = r_instr_cnt;
`else
  assign instr_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller : randomized scoreboard bench for mc_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                         OP_SW = 6'b101011;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_OR = 6'b100101, FN_SLT = 6'b101010;
  localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000,
                         A_OR = 3'b001, A_SLT = 3'b111;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        ext_op;
    logic        illegal;
    logic [31:0] cnt;
  } obs_t;

  typedef struct packed {
    obs_t v;
    obs_t m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = 6'd0, funct = 6'd0;
  logic        zero = 1'b0, mem_ready = 1'b1;
  logic        pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic        alu_src_a, ext_op, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_op(ext_op),
    .illegal(illegal), .state_o(state_o), .instr_cnt(instr_cnt)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_illegal = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  // Reference model: expected outputs for one cycle spent in spec state p
  function automatic exp_t expect_phase(input int p, input logic mr);
    exp_t e;
    e.v = '0;
    e.m = '1;
    e.v.st      = p[3:0];
    e.v.illegal = m_illegal;
    e.v.cnt     = m_cnt;
    case (p)
      0: begin e.v.alu_src_b = 2'b01; e.v.alu_ctrl = A_ADD; e.v.ir_write = mr; e.v.pc_en = mr; end
      1: begin e.v.alu_src_b = 2'b11; e.v.alu_ctrl = A_ADD; e.v.ext_op = 1'b1; end
      2: begin e.v.alu_src_a = 1'b1; e.v.alu_src_b = 2'b10; e.v.alu_ctrl = A_ADD; e.v.ext_op = 1'b1; end
      3: e.v.iord = 1'b1;
      4: begin e.v.reg_write = 1'b1; e.v.mem_to_reg = 1'b1; end
      5: begin e.v.iord = 1'b1; e.v.mem_write = 1'b1; end
      6: begin
        e.v.alu_src_a = 1'b1;
        case (funct)
          FN_ADD: e.v.alu_ctrl = A_ADD;
          FN_SUB: e.v.alu_ctrl = A_SUB;
          FN_AND: e.v.alu_ctrl = A_AND;
          FN_OR:  e.v.alu_ctrl = A_OR;
          FN_SLT: e.v.alu_ctrl = A_SLT;
          default: e.m.alu_ctrl = 3'b000;
        endcase
      end
      7: begin e.v.reg_write = 1'b1; e.v.reg_dst = 1'b1; end
      8: begin
        e.v.alu_src_a = 1'b1; e.v.alu_ctrl = A_SUB; e.v.pc_src = 2'b01;
        e.v.pc_en = (op == OP_BEQ) ? zero : !zero;
      end
      9: begin
        e.v.alu_src_a = 1'b1; e.v.alu_src_b = 2'b10;
        e.v.ext_op = !(op == OP_ANDI || op == OP_ORI);
        case (op)
          OP_SLTI: e.v.alu_ctrl = A_SLT;
          OP_ANDI: e.v.alu_ctrl = A_AND;
          OP_ORI:  e.v.alu_ctrl = A_OR;
          default: e.v.alu_ctrl = A_ADD;
        endcase
      end
      10: e.v.reg_write = 1'b1;
      11: begin e.v.pc_src = 2'b10; e.v.pc_en = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return f == FN_ADD || f == FN_SUB || f == FN_AND || f == FN_OR || f == FN_SLT;
  endfunction

  function automatic bit op_ok(input logic [5:0] o);
    return o == OP_R || o == OP_J || o == OP_BEQ || o == OP_BNE || o == OP_ADDI ||
           o == OP_SLTI || o == OP_ANDI || o == OP_ORI || o == OP_LW || o == OP_SW;
  endfunction

  task automatic step(input logic mr, input logic rn, input exp_t e);
    mem_ready = mr;
    rst_n     = rn;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic [3:0] cur);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.m = '1;
      e.v.st      = (i == 0) ? cur : 4'd0;
      e.v.illegal = m_illegal;
      e.v.cnt     = m_cnt;
      step(1'b1, 1'b0, e);
      if (i == 0) begin
        m_illegal = 1'b0;
        m_cnt     = 32'd0;
      end
    end
  endtask

  // Runs one instruction; stall counts < 0 are randomized, abort resets in MEMWR
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fs, input int ms, input bit abort);
    int   ph[$];
    int   n;
    logic mr;
    bit   bad;
    op = o; funct = f; zero = z;
    bad = 1'b0;
    case (o)
      OP_LW:                        ph = '{0, 1, 2, 3, 4};
      OP_SW:                        ph = '{0, 1, 2, 5};
      OP_R: if (funct_ok(f))        ph = '{0, 1, 6, 7};
            else begin              ph = '{0, 1, 6}; bad = 1'b1; end
      OP_BEQ, OP_BNE:               ph = '{0, 1, 8};
      OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI:                       ph = '{0, 1, 9, 10};
      OP_J:                         ph = '{0, 1, 11};
      default: begin                ph = '{0, 1}; bad = 1'b1; end
    endcase
    foreach (ph[i]) begin
      if (ph[i] == 5 && abort) begin
        step(1'b0, 1'b1, expect_phase(5, 1'b0));
        do_reset(2, 4'd5);
        return;
      end
      if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) begin
        n = (ph[i] == 0) ? fs : ms;
        if (n < 0) n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, expect_phase(ph[i], 1'b0));
        step(1'b1, 1'b1, expect_phase(ph[i], 1'b1));
      end else begin
        mr = 1'($urandom_range(0, 1));
        step(mr, 1'b1, expect_phase(ph[i], mr));
      end
    end
    if (bad) m_illegal = 1'b1;
`ifdef MC_CONTROLLER_PERF_EN
    m_cnt = m_cnt + 32'd1;
`endif
  endtask

  // Monitor: compare every cycle the stimulus side has queued an expectation
  initial begin
    exp_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st = state_o;       a.pc_en = pc_en;         a.pc_src = pc_src;
        a.iord = iord;        a.mem_write = mem_write; a.ir_write = ir_write;
        a.reg_write = reg_write; a.reg_dst = reg_dst;  a.mem_to_reg = mem_to_reg;
        a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.alu_ctrl = alu_ctrl;
        a.ext_op = ext_op;    a.illegal = illegal;     a.cnt = instr_cnt;
        checks++;
        if (((a ^ e.v) & e.m) !== '0) begin
          errors++;
          $display("FAIL outputs t=%0t exp_state=%0d actual=%h required=%h mask=%h",
                   $time, e.v.st, a, e.v, e.m);
        end
      end
    end
  end

  initial begin
    logic [5:0] o, f;
    int         r;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2, 4'd0);

    run_instr(OP_LW, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LW, 6'd0, 1'b0, 0, 3, 1'b0);
    run_instr(OP_R, FN_SUB, 1'b0, 0, 0, 1'b0);
    run_instr(OP_R, 6'b111111, 1'b0, 0, 0, 1'b0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 1, 0, 1'b0);
    do_reset(2, 4'd0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_BEQ, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_BNE, 6'd0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_ORI, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_SLTI, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_ANDI, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_SW, 6'd0, 1'b0, 0, 2, 1'b1);
    run_instr(OP_LW, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_SW, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b0);
    run_instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0);
    run_instr(OP_R, FN_OR, 1'b0, 0, 0, 1'b0);
    run_instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b0);
    do_reset(2, 4'd0);

    for (int i = 0; i < 300; i++) begin
      if (i % 40 == 39) do_reset(2, 4'd0);
      r = $urandom_range(0, 10);
      case (r)
        0: o = OP_LW;   1: o = OP_SW;   2: o = OP_R;    3: o = OP_BEQ;
        4: o = OP_BNE;  5: o = OP_ADDI; 6: o = OP_SLTI; 7: o = OP_ANDI;
        8: o = OP_ORI;  9: o = OP_J;
        default: begin
          o = 6'($urandom);
          while (op_ok(o)) o = 6'($urandom);
        end
      endcase
      case ($urandom_range(0, 5))
        0: f = FN_ADD; 1: f = FN_SUB; 2: f = FN_AND; 3: f = FN_OR; 4: f = FN_SLT;
        default: f = 6'($urandom);
      endcase
      run_instr(o, f, 1'($urandom_range(0, 1)), -1, -1,
                (o == OP_SW) && ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
